scrambler_seq: RTL
==================

# scrambler_seq

Frame sequencer for the 15-bit PRBS15 scrambler (polynomial x^15 + x^14 + 1). It loads a seed at the start of each frame and counts beats to a programmed frame length. Each accepted data beat is XOR'd with DATA_W keystream bits, and the LFSR advances DATA_W steps per beat. It sits between the framer (upstream valid/ready stream) and the line encoder (downstream valid/ready stream) and signals frame completion to the link controller.

## Interface
- DATA_W, 8: bits per beat; legal range 1..15.
- LEN_W, 12: width of the frame-length field.

- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: frame request. Sampled only while idle.
- cfg_seed, in, 15: LFSR seed. Captured on an accepted start.
- cfg_len, in, LEN_W: frame length in beats. Captured on an accepted start.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at the end of a frame.
- seed_err, out, 1: one-cycle pulse when an all-zero seed is captured (see Configuration).
- s_valid, in, 1: upstream data valid.
- s_ready, out, 1: upstream ready.
- s_data, in, DATA_W: plain data; bit 0 is transmitted first.
- m_valid, out, 1: downstream data valid.
- m_ready, in, 1: downstream ready.
- m_data, out, DATA_W: scrambled data.
- m_last, out, 1: marks the final beat of a frame; qualified by m_valid.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - A start with cfg_len != 0 is accepted. On that edge: LFSR <= seed, remaining count <= cfg_len, state <= RUN.
  - A start with cfg_len == 0 is ignored; no busy, no done.
- LFSR step:
  - fb = s[14] ^ s[13]
  - s_next = {s[13:0], fb}
  - Key bit k of a beat is the fb of step k. Steps are taken in order k = 0..DATA_W-1.
  - m_data[k] = s_data[k] ^ key[k].
  - The LFSR advances exactly DATA_W steps per accepted input beat, and never otherwise.
- RUN:
  - s_ready = (remaining != 0) && (!m_valid || m_ready).
  - Input handshake (s_valid && s_ready):
    - Register the scrambled beat into m_data and set m_valid.
    - Decrement remaining.
    - When remaining was 1, set m_last and go to DRAIN.
  - m_valid and m_data hold stable while m_valid && !m_ready.
- DRAIN:
  - s_ready = 0.
  - When the m_last beat handshakes: clear m_valid and m_last, pulse done, return to IDLE.
- start while busy is ignored. Config inputs are not re-sampled mid-frame.
- Reset mid-frame discards the frame: no done, no m_last.
- Reset values: state IDLE, LFSR 15'h0, remaining 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0, seed_err 0, s_ready 0.

## Timing
- If start is accepted at edge T: busy = 1 and s_ready can be 1 from T+1.
- Input-to-output latency is 1 cycle. The output is fully registered; there is no combinational path from s_data to m_data.
- Throughput is 1 beat per cycle while m_ready = 1. With back-to-back frames there is one IDLE cycle between done and the next accepted start.
- When the m_last handshake occurs at edge E:
  - done = 1 and busy = 0 during cycle E+1.
  - A new start is accepted at the earliest at edge E+1.
- Simultaneous output handshake and input handshake in RUN: both complete in the same cycle, with no bubble.

## Configuration
- SCRAMBLER_SEQ_ZERO_GUARD_EN
  - Defined: an all-zero cfg_seed is replaced by 15'h7FFF on capture, and seed_err pulses in cycle T+1.
  - Not defined: a zero seed is loaded as-is, the keystream is all zero (m_data = s_data), and seed_err is tied 0.

## Test plan
- Keystream check. Setup: DATA_W = 8, seed 15'h7FFF, cfg_len 2, m_ready = 1. Send s_data 8'h00, 8'h00 -> required m_data 8'h00, 8'h40, with m_last on beat 2. Repeat with inputs 8'hFF, 8'hFF -> required 8'hFF, 8'hBF.
- Backpressure. Hold m_ready = 0 for 5 cycles mid-frame -> m_data stays stable, s_ready = 0, and the LFSR does not advance. Output after release matches the no-stall reference stream.
- Frame boundary. cfg_len 3 -> exactly 3 beats are accepted and m_last is on the third. done pulses one cycle after the m_last handshake, busy falls in the same cycle, and a start that cycle is accepted.
- Ignored start. start while busy, and start with cfg_len 0 -> no state change, no done, and the config captured at the original start is retained.
- Reset mid-frame. Assert rst_n low after beat 1 of 4 -> all outputs return to their reset values asynchronously, with no done and no m_last afterward. A subsequent frame reproduces the keystream from its seed.
- Zero seed. seed 15'h0000 -> with the macro: seed_err pulses and the output equals the 15'h7FFF keystream. Without the macro: m_data = s_data.

Source files
------------

// File: rtl/scrambler_seq.sv
// scrambler_seq: frame sequencer for a PRBS15 (x^15 + x^14 + 1) data scrambler.
// Optional feature: define SCRAMBLER_SEQ_ZERO_GUARD_EN to substitute 15'h7FFF for an all-zero seed.
module scrambler_seq #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [14:0]       cfg_seed,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              seed_err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  state_t             state_next;
  logic [14:0]        lfsr;
  logic [14:0]        lfsr_adv;
  logic [14:0]        lfsr_tmp;
  logic [14:0]        seed_eff;
  logic               seed_zero;
  logic [DATA_W-1:0]  key;
  logic [LEN_W-1:0]   remaining;
  logic               accept;
  logic               in_hs;
  logic               out_hs;
  logic               last_in;

`ifdef SCRAMBLER_SEQ_ZERO_GUARD_EN
  assign seed_zero = (cfg_seed == 15'h0000);
  assign seed_eff  = seed_zero ? 15'h7FFF : cfg_seed;
`else
  assign seed_zero = 1'b0;
  assign seed_eff  = cfg_seed;
`endif

  assign accept  = (state == IDLE) && start && (cfg_len != '0);
  assign s_ready = (state == RUN) && (remaining != '0) && (!m_valid || m_ready);
  assign in_hs   = s_valid && s_ready;
  assign out_hs  = m_valid && m_ready;
  assign last_in = (remaining == LEN_W'(1));
  assign busy    = (state != IDLE);

  // Run the LFSR DATA_W steps ahead; key bit k is the feedback of step k.
  always_comb begin
    lfsr_tmp = lfsr;
    key      = '0;
    for (int k = 0; k < DATA_W; k++) begin
      key[k]   = lfsr_tmp[14] ^ lfsr_tmp[13];
      lfsr_tmp = {lfsr_tmp[13:0], key[k]};
    end
    lfsr_adv = lfsr_tmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (in_hs && last_in) state_next = DRAIN;
      DRAIN:   if (out_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new input beat in the same cycle as an output handshake overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= 15'h0000;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done      <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      seed_err <= 1'b0;
      if (accept) begin
        lfsr      <= seed_eff;
        remaining <= cfg_len;
        seed_err  <= seed_zero;
      end
      if (out_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        if (state == DRAIN) done <= 1'b1;
      end
      if (in_hs) begin
        m_valid   <= 1'b1;
        m_data    <= s_data ^ key;
        lfsr      <= lfsr_adv;
        remaining <= remaining - LEN_W'(1);
        if (last_in) m_last <= 1'b1;
      end
    end
  end

endmodule
